snake_move_scheduler: RTL and testbench

- Sequences snake motion. Turns debounced key pulses into a one-cycle move strobe at the current game speed, plus the registered one-hot heading.
- Buffers up to two pending turns, so fast double-taps apply on consecutive moves.
- Owns the game state machine (idle/run/pause/over) and speed-up on food.
- Sits between the key debounce front end and the snake body/collision logic.

---
 rtl/snake_move_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_snake_move_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_scheduler.sv
// Snake motion scheduler: game state machine, step timer, two-entry turn
// queue and speed-up on food.
//   clk, rst          : clock, synchronous active-high reset
//   key_turn_left/right, key_start, key_reset : debounced one-cycle key pulses
//   collide, eat      : pulses from the body/collision logic
//   step              : one-cycle move strobe
//   dir               : one-hot heading (UP=1000 DOWN=0100 LEFT=0010 RIGHT=0001)
//   state             : IDLE=00 RUN=01 PAUSE=10 OVER=11
//   level             : speed level, saturates at 15
//   queue_cnt         : pending turns (0..2)
module snake_move_scheduler #(
    parameter int unsigned TICK_INIT      = 20,
    parameter int unsigned TICK_MIN       = 5,
    parameter int unsigned TICK_DEC       = 2,
    parameter int unsigned EATS_PER_LEVEL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_turn_left,
    input  logic       key_turn_right,
    input  logic       key_start,
    input  logic       key_reset,
    input  logic       collide,
    input  logic       eat,
    output logic       step,
    output logic [3:0] dir,
    output logic [1:0] state,
    output logic [3:0] level,
    output logic [1:0] queue_cnt
);

    localparam int unsigned CW = 8;
    localparam int unsigned PW = 9;
    localparam logic [3:0]  DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            step_q, step_d;
    logic [3:0]      dir_q, dir_d;
    logic [3:0]      level_q, level_d;
    logic [1:0]      qcnt_q, qcnt_d;
    logic [1:0]      turn_q, turn_d;     // [0] is the head; 1 = right turn
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   eat_q, eat_d;
    logic [CW-1:0]   period_q, period_d;

    logic            reinit_c;
    logic            fire_c;
    logic            pop_c;
    logic            push_c;
    logic signed [PW-1:0] per_dec_c;

    // Rotations on the one-hot heading {UP, DOWN, LEFT, RIGHT}
    function automatic logic [3:0] rot_left(input logic [3:0] d);
        return {d[0], d[1], d[3], d[2]};
    endfunction

    function automatic logic [3:0] rot_right(input logic [3:0] d);
        return {d[1], d[0], d[2], d[3]};
    endfunction

    // Re-init on key_reset anywhere, or on acknowledging game over
    assign reinit_c  = key_reset || (state_q == S_OVER && key_start);
    assign per_dec_c = $signed({1'b0, period_q}) - $signed(PW'(TICK_DEC));

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            step_q   <= 1'b0;
            dir_q    <= DIR_RIGHT;
            level_q  <= '0;
            qcnt_q   <= '0;
            turn_q   <= '0;
            cnt_q    <= '0;
            eat_q    <= '0;
            period_q <= CW'(TICK_INIT);
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            level_q  <= level_d;
            qcnt_q   <= qcnt_d;
            turn_q   <= turn_d;
            cnt_q    <= cnt_d;
            eat_q    <= eat_d;
            period_q <= period_d;
        end
    end

    // Next-state logic; collide outranks key_start in RUN
    always_comb begin
        state_d = state_q;
        if (key_reset) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (key_start) state_d = S_RUN;
                S_RUN: begin
                    if (collide)        state_d = S_OVER;
                    else if (key_start) state_d = S_PAUSE;
                end
                S_PAUSE: if (key_start) state_d = S_RUN;
                S_OVER:  if (key_start) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Step timer, turn queue, heading and level update
    always_comb begin
        step_d   = 1'b0;
        dir_d    = dir_q;
        level_d  = level_q;
        qcnt_d   = qcnt_q;
        turn_d   = turn_q;
        cnt_d    = cnt_q;
        eat_d    = eat_q;
        period_d = period_q;
        fire_c   = 1'b0;
        pop_c    = 1'b0;
        push_c   = 1'b0;

        if (reinit_c) begin
            dir_d    = DIR_RIGHT;
            level_d  = '0;
            qcnt_d   = '0;
            turn_d   = '0;
            cnt_d    = '0;
            eat_d    = '0;
            period_d = CW'(TICK_INIT);
        end else if (state_q == S_IDLE) begin
            if (key_start) cnt_d = '0;
        end else if (state_q == S_RUN) begin
            if (collide) begin
                qcnt_d = '0;
            end else begin
                if (!key_start) begin
                    // >= so a shrunken period fires on the very next cycle
                    fire_c = (cnt_q >= period_q - CW'(1));
                    cnt_d  = fire_c ? '0 : cnt_q + CW'(1);
                    step_d = fire_c;
                    pop_c  = fire_c && (qcnt_q != 2'd0);
                    push_c = (key_turn_left ^ key_turn_right)
                             && ((qcnt_q != 2'd2) || pop_c);
                    if (pop_c) begin
                        dir_d = turn_q[0] ? rot_right(dir_q) : rot_left(dir_q);
                    end
                    // Pop before push: a turn pushed into an empty queue
                    // waits for the following step
                    case ({pop_c, push_c})
                        2'b10: begin
                            turn_d[0] = turn_q[1];
                            qcnt_d    = qcnt_q - 2'd1;
                        end
                        2'b01: begin
                            if (qcnt_q == 2'd0) turn_d[0] = key_turn_right;
                            else                turn_d[1] = key_turn_right;
                            qcnt_d = qcnt_q + 2'd1;
                        end
                        2'b11: begin
                            if (qcnt_q == 2'd2) begin
                                turn_d[0] = turn_q[1];
                                turn_d[1] = key_turn_right;
                            end else begin
                                turn_d[0] = key_turn_right;
                            end
                        end
                        default: ;
                    endcase
                end
                if (eat) begin
                    if (eat_q + CW'(1) == CW'(EATS_PER_LEVEL)) begin
                        eat_d = '0;
                        if (level_q != 4'hF) level_d = level_q + 4'd1;
                        if (per_dec_c < $signed(PW'(TICK_MIN)))
                            period_d = CW'(TICK_MIN);
                        else
                            period_d = per_dec_c[CW-1:0];
                    end else begin
                        eat_d = eat_q + CW'(1);
                    end
                end
            end
        end
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign state     = state_q;
    assign level     = level_q;
    assign queue_cnt = qcnt_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
module tb_snake_move_scheduler;

    localparam int TICK_INIT = 20;
    localparam int TICK_MIN  = 5;
    localparam int TICK_DEC  = 2;
    localparam int EPL       = 4;

    // key vector bits
    localparam logic [5:0] K_NONE  = 6'b000000;
    localparam logic [5:0] K_LEFT  = 6'b000001;
    localparam logic [5:0] K_RIGHT = 6'b000010;
    localparam logic [5:0] K_START = 6'b000100;
    localparam logic [5:0] K_RST   = 6'b001000;
    localparam logic [5:0] K_COL   = 6'b010000;
    localparam logic [5:0] K_EAT   = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_turn_left = 1'b0, key_turn_right = 1'b0;
    logic       key_start = 1'b0, key_reset = 1'b0;
    logic       collide = 1'b0, eat = 1'b0;
    logic       step;
    logic [3:0] dir;
    logic [1:0] state;
    logic [3:0] level;
    logic [1:0] queue_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_move_scheduler #(
        .TICK_INIT(TICK_INIT), .TICK_MIN(TICK_MIN),
        .TICK_DEC(TICK_DEC), .EATS_PER_LEVEL(EPL)
    ) dut (
        .clk(clk), .rst(rst),
        .key_turn_left(key_turn_left), .key_turn_right(key_turn_right),
        .key_start(key_start), .key_reset(key_reset),
        .collide(collide), .eat(eat),
        .step(step), .dir(dir), .state(state), .level(level),
        .queue_cnt(queue_cnt)
    );

    typedef struct {
        logic [5:0]  keys;
        int          idle_n;
        logic        step;
        logic [3:0]  dir;
        logic [1:0]  state;
        logic [1:0]  qcnt;
        logic [3:0]  level;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] k, input int n, input logic s,
                                input logic [3:0] d, input logic [1:0] st,
                                input logic [1:0] q, input logic [3:0] l);
        vec_t v;
        v.keys = k; v.idle_n = n; v.step = s; v.dir = d;
        v.state = st; v.qcnt = q; v.level = l;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic s, input logic [3:0] d,
                                 input logic [1:0] st, input logic [1:0] q,
                                 input logic [3:0] l);
        check({tag, ".step"},  int'(step),      int'(s));
        check({tag, ".dir"},   int'(dir),       int'(d));
        check({tag, ".state"}, int'(state),     int'(st));
        check({tag, ".qcnt"},  int'(queue_cnt), int'(q));
        check({tag, ".level"}, int'(level),     int'(l));
    endtask

    // Drive a key vector for one clock edge, then sample just after it
    task automatic tick(input logic [5:0] k);
        key_turn_left  = k[0];
        key_turn_right = k[1];
        key_start      = k[2];
        key_reset      = k[3];
        collide        = k[4];
        eat            = k[5];
        @(posedge clk);
        #1;
        {eat, collide, key_reset, key_start, key_turn_right, key_turn_left} = 6'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Idle cycles until step is seen; -1 when the budget runs out
    task automatic cycles_to_step(input int budget, output int n);
        n = 0;
        do begin
            tick(K_NONE);
            n++;
        end while (!step && n < budget);
        if (!step) n = -1;
    endtask

    // ---------------- behavioural reference model ----------------
    int  m_state, m_head, m_level, m_period, m_cnt, m_eat;
    bit  m_step;
    bit  m_q[$];

    function automatic logic [3:0] head_onehot(input int h);
        case (h)
            0: return 4'b0001;  // RIGHT
            1: return 4'b1000;  // UP
            2: return 4'b0010;  // LEFT
            default: return 4'b0100;  // DOWN
        endcase
    endfunction

    task automatic model_reinit();
        m_state = 0; m_head = 0; m_level = 0; m_period = TICK_INIT;
        m_cnt = 0; m_eat = 0; m_step = 0;
        m_q.delete();
    endtask

    task automatic model_cycle(input logic [5:0] k);
        bit t;
        m_step = 0;
        if (k[3]) begin
            model_reinit();
            return;
        end
        case (m_state)
            0: if (k[2]) begin m_state = 1; m_cnt = 0; end
            1: begin
                if (k[4]) begin
                    m_state = 3;
                    m_q.delete();
                end else begin
                    if (k[2]) begin
                        m_state = 2;
                    end else begin
                        if (m_cnt + 1 >= m_period) begin
                            m_step = 1;
                            m_cnt  = 0;
                            if (m_q.size() > 0) begin
                                t = m_q.pop_front();
                                m_head = (m_head + (t ? 3 : 1)) % 4;
                            end
                        end else begin
                            m_cnt++;
                        end
                        if (k[0] != k[1] && m_q.size() < 2) m_q.push_back(k[1]);
                    end
                    if (k[5]) begin
                        m_eat++;
                        if (m_eat == EPL) begin
                            m_eat = 0;
                            if (m_level < 15) m_level++;
                            m_period = (m_period - TICK_DEC < TICK_MIN) ? TICK_MIN
                                                                        : m_period - TICK_DEC;
                        end
                    end
                end
            end
            2: if (k[2]) m_state = 1;
            default: if (k[2]) model_reinit();
        endcase
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int steps_seen;
        logic [5:0] k;

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 4'b0001, 2'b00, 2'd0, 4'd0);
        rst = 1'b0;

        // ---------- table: start, step timing, turn queue ----------
        vecs.push_back(mk(K_NONE,          0, 0, 4'b0001, 2'b00, 0, 0));
        vecs.push_back(mk(K_START,         0, 0, 4'b0001, 2'b01, 0, 0));
        vecs.push_back(mk(K_NONE,         18, 0, 4'b0001, 2'b01, 0, 0));
        vecs.push_back(mk(K_NONE,          0, 1, 4'b0001, 2'b01, 0, 0));
        vecs.push_back(mk(K_NONE,         18, 0, 4'b0001, 2'b01, 0, 0));
        vecs.push_back(mk(K_NONE,          0, 1, 4'b0001, 2'b01, 0, 0));
        vecs.push_back(mk(K_LEFT,          0, 0, 4'b0001, 2'b01, 1, 0));
        vecs.push_back(mk(K_NONE,          0, 0, 4'b0001, 2'b01, 1, 0));
        vecs.push_back(mk(K_RIGHT,         0, 0, 4'b0001, 2'b01, 2, 0));
        vecs.push_back(mk(K_NONE,         15, 0, 4'b0001, 2'b01, 2, 0));
        vecs.push_back(mk(K_NONE,          0, 1, 4'b1000, 2'b01, 1, 0));
        vecs.push_back(mk(K_NONE,         18, 0, 4'b1000, 2'b01, 1, 0));
        vecs.push_back(mk(K_NONE,          0, 1, 4'b0001, 2'b01, 0, 0));
        vecs.push_back(mk(K_LEFT,          0, 0, 4'b0001, 2'b01, 1, 0));
        vecs.push_back(mk(K_LEFT,          0, 0, 4'b0001, 2'b01, 2, 0));
        vecs.push_back(mk(K_RIGHT,         0, 0, 4'b0001, 2'b01, 2, 0));
        vecs.push_back(mk(K_LEFT|K_RIGHT,  0, 0, 4'b0001, 2'b01, 2, 0));
        vecs.push_back(mk(K_NONE,         15, 1, 4'b1000, 2'b01, 1, 0));
        vecs.push_back(mk(K_LEFT|K_RIGHT,  0, 0, 4'b1000, 2'b01, 1, 0));
        vecs.push_back(mk(K_RST,           0, 0, 4'b0001, 2'b00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].keys);
            repeat (vecs[i].idle_n) tick(K_NONE);
            check_outputs($sformatf("vec%0d", i), vecs[i].step, vecs[i].dir,
                          vecs[i].state, vecs[i].qcnt, vecs[i].level);
        end

        // ---------- eat / level-up / period clamp / level saturation ----------
        do_reset();
        tick(K_START);
        repeat (4) tick(K_EAT);
        check("eat.level1", int'(level), 1);
        cycles_to_step(100, n);
        cycles_to_step(100, n);
        check("eat.gap_lvl1", n, 18);
        repeat (28) tick(K_EAT);
        check("eat.level8", int'(level), 8);
        cycles_to_step(100, n);
        cycles_to_step(100, n);
        check("eat.gap_clamped", n, 5);
        repeat (32) tick(K_EAT);
        check("eat.level_sat", int'(level), 15);
        cycles_to_step(100, n);
        cycles_to_step(100, n);
        check("eat.gap_sat", n, 5);

        // ---------- pause mid-period and resume ----------
        do_reset();
        tick(K_START);
        repeat (7) tick(K_NONE);
        tick(K_START);
        check("pause.state", int'(state), 2);
        steps_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick((i % 7 == 3) ? (K_LEFT | K_EAT) : K_NONE);
            if (step) steps_seen++;
        end
        check("pause.no_step", steps_seen, 0);
        check("pause.qcnt", int'(queue_cnt), 0);
        check("pause.level", int'(level), 0);
        tick(K_START);
        check("resume.state", int'(state), 1);
        cycles_to_step(100, n);
        check("resume.gap", n, 13);

        // ---------- collide on a scheduled step, acknowledge, key_reset ----------
        do_reset();
        tick(K_START);
        tick(K_LEFT);
        repeat (4) tick(K_EAT);
        cycles_to_step(100, n);
        check("col.first_step_seen", int'(n > 0), 1);
        check("col.dir_up", int'(dir), 4'b1000);
        check("col.level", int'(level), 1);
        tick(K_RIGHT);
        repeat (16) tick(K_NONE);
        check("col.qcnt_before", int'(queue_cnt), 1);
        tick(K_COL | K_START | K_EAT);
        check_outputs("col.hit", 1'b0, 4'b1000, 2'b11, 2'd0, 4'd1);
        tick(K_LEFT | K_EAT);
        check_outputs("col.over_ign", 1'b0, 4'b1000, 2'b11, 2'd0, 4'd1);
        tick(K_START);
        check_outputs("col.ack", 1'b0, 4'b0001, 2'b00, 2'd0, 4'd0);
        tick(K_START);
        repeat (5) tick(K_NONE);
        tick(K_RST | K_START | K_LEFT);
        check_outputs("keyreset.run", 1'b0, 4'b0001, 2'b00, 2'd0, 4'd0);

        // ---------- randomized run against the reference model ----------
        do_reset();
        model_reinit();
        for (int c = 0; c < 4000; c++) begin
            k[0] = ($urandom_range(0, 99) < 12);
            k[1] = ($urandom_range(0, 99) < 12);
            k[2] = ($urandom_range(0, 99) < 3);
            k[3] = ($urandom_range(0, 199) < 1);
            k[4] = ($urandom_range(0, 99) < 1);
            k[5] = ($urandom_range(0, 99) < 10);
            model_cycle(k);
            tick(k);
            check_outputs($sformatf("rnd%0d", c), m_step, head_onehot(m_head),
                          2'(m_state), 2'(m_q.size()), 4'(m_level));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
